counter4: RTL and testbench

- Free-running modulo up-counter with a registered count output and terminal-count/wrap status flags.
- Used as a simple timebase or sequence generator in practice and bring-up designs.
- No control inputs: it counts on every clock edge once reset is released.
- The default configuration is a 4-bit binary counter, 0..15, that wraps to 0.

---
 rtl/counter4.sv | 44 ++++
 tb/tb_counter4.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/counter4.sv
// counter4: free-running modulo up-counter with combinational terminal count and registered wrap pulse
module counter4 #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULO    = 64'd1 << WIDTH,
  parameter longint unsigned STEP      = 1,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter4: WIDTH out of range 1..32");
  end
  if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
    $error("counter4: MODULO out of range 2..2**WIDTH");
  end
  if (STEP < 1 || STEP >= MODULO) begin : g_bad_step
    $error("counter4: STEP out of range 1..MODULO-1");
  end
  if (RESET_VAL >= MODULO) begin : g_bad_reset
    $error("counter4: RESET_VAL must be below MODULO");
  end
  // one extra bit keeps the carry so the wrap compare sees the true sum
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, out} + STEP_W;
    tc  = sum >= MOD_W;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= RST_V;
      wrap <= 1'b0;
    end else begin
      out  <= tc ? WIDTH'(sum - MOD_W) : sum[WIDTH-1:0];
      wrap <= tc;
    end
  end
endmodule

// File: tb/tb_counter4.sv
// tb_counter4: scoreboard bench for default, modulo-10 and step-3/reset-5 counters
module tb_counter4;
  typedef struct packed {
    logic [3:0] o;
    logic       t;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] out0, out1, out2;
  logic       tc0, tc1, tc2, wrap0, wrap1, wrap2;
  int         vectors = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  counter4 d0 (.clk(clk), .rst_n(rst_n), .out(out0), .tc(tc0), .wrap(wrap0));
  counter4 #(.MODULO(10)) d1 (.clk(clk), .rst_n(rst_n), .out(out1), .tc(tc1), .wrap(wrap1));
  counter4 #(.STEP(3), .RESET_VAL(5)) d2 (.clk(clk), .rst_n(rst_n), .out(out2), .tc(tc2), .wrap(wrap2));

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk) rst_n = 1'b0;
    repeat (2) begin
      sb.push_back('{o: 4'd0, t: 1'b0, w: 1'b0});
      sb.push_back('{o: 4'd5, t: 1'b0, w: 1'b0});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL reset_hold_default out/tc/wrap=%0d/%b/%b required %0d/%b/%b", out0, tc0, wrap0, e.o, e.t, e.w);
      end
      e = sb.pop_front();
      vectors++;
      if ({out2, tc2, wrap2} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL reset_hold_step3 out/tc/wrap=%0d/%b/%b required %0d/%b/%b", out2, tc2, wrap2, e.o, e.t, e.w);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.push_back('{o: 4'd0, t: 1'b0, w: 1'b0});
    #1;
    e = sb.pop_front();
    vectors++;
    if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
      errors++;
      $display("FAIL reset_async out/tc/wrap=%0d/%b/%b required %0d/%b/%b", out0, tc0, wrap0, e.o, e.t, e.w);
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      sb.push_back('{o: 4'(k % 16), t: (k % 16 == 15), w: (k % 16 == 0)});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL free_run k=%0d out/tc/wrap=%0d/%b/%b required %0d/%b/%b", k, out0, tc0, wrap0, e.o, e.t, e.w);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    repeat (9) @(posedge clk);
    @(negedge clk);
    sb.push_back('{o: 4'd9, t: 1'b0, w: 1'b0});
    e = sb.pop_front();
    vectors++;
    if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
      errors++;
      $display("FAIL mid_reset_pre out/tc/wrap=%0d/%b/%b required %0d/%b/%b", out0, tc0, wrap0, e.o, e.t, e.w);
    end
    #1 rst_n = 1'b0;
    sb.push_back('{o: 4'd0, t: 1'b0, w: 1'b0});
    #2;
    e = sb.pop_front();
    vectors++;
    if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
      errors++;
      $display("FAIL mid_reset_async out/tc/wrap=%0d/%b/%b required %0d/%b/%b", out0, tc0, wrap0, e.o, e.t, e.w);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back('{o: 4'(k), t: 1'b0, w: 1'b0});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL mid_reset_restart k=%0d out/tc/wrap=%0d/%b/%b required %0d/%b/%b", k, out0, tc0, wrap0, e.o, e.t, e.w);
      end
    end
  endtask

  task automatic test_modulo();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      sb.push_back('{o: 4'(k % 10), t: (k % 10 == 9), w: (k % 10 == 0)});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({out1, tc1, wrap1} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL modulo10 k=%0d out/tc/wrap=%0d/%b/%b required %0d/%b/%b", k, out1, tc1, wrap1, e.o, e.t, e.w);
      end
    end
  endtask

  task automatic test_step();
    exp_t e;
    int   v;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      v = 5 + 3 * k;
      sb.push_back('{o: 4'(v % 16), t: ((v % 16) >= 13), w: ((v / 16) != ((v - 3) / 16))});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({out2, tc2, wrap2} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL step3 k=%0d out/tc/wrap=%0d/%b/%b required %0d/%b/%b", k, out2, tc2, wrap2, e.o, e.t, e.w);
      end
    end
  endtask

  task automatic test_long_run();
    exp_t e;
    int   pulses = 0;
    do_reset();
    for (int k = 1; k <= 1000; k++) begin
      sb.push_back('{o: 4'(k % 16), t: (k % 16 == 15), w: (k % 16 == 0)});
      @(posedge clk);
      @(negedge clk);
      if (wrap0 === 1'b1) pulses++;
      e = sb.pop_front();
      vectors++;
      if ({out0, tc0, wrap0} !== {e.o, e.t, e.w}) begin
        errors++;
        $display("FAIL long_run k=%0d out/tc/wrap=%0d/%b/%b required %0d/%b/%b", k, out0, tc0, wrap0, e.o, e.t, e.w);
      end
    end
    vectors++;
    if (pulses !== 1000 / 16) begin
      errors++;
      $display("FAIL long_run_wrap_count got %0d required %0d", pulses, 1000 / 16);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_run();
    test_mid_reset();
    test_modulo();
    test_step();
    test_long_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
